// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: synchronise, debounce and edge-detect raw pins, with a small status/interrupt register bank
module gpio_input_conditioner #(
  parameter int NPINS        = 32,
  parameter int DIV          = 16,
  parameter int STABLE_TICKS = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  input  logic [NPINS-1:0] pins_in,
  output logic [NPINS-1:0] pins_clean,
  output logic             irq
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  logic [NPINS-1:0] sync1, sync2, rise_en, fall_en, pending;
  logic [NPINS-1:0] accept, clean_nxt, rise, fall, clr;
  logic [CNT_W-1:0] cnt [NPINS];
  logic [CNT_W-1:0] cnt_nxt [NPINS];
  logic [PW-1:0]    presc;
  logic             tick, wr_c, unused_bits;
  assign tick        = presc == PW'(DIV - 1);
  assign rise        = clean_nxt & ~pins_clean;
  assign fall        = ~clean_nxt & pins_clean;
  assign wr_c        = we && addr[3:0] == 4'hC;
  assign clr         = wr_c ? wdata[NPINS-1:0] : '0;
  assign irq         = |pending;
  assign clean_nxt   = pins_clean ^ accept;
  assign unused_bits = ^{addr[31:4], wdata};
  // per-pin debounce: any agreement with the clean level discards progress
  always_comb begin
    accept = '0;
    for (int i = 0; i < NPINS; i++) begin
      accept[i]  = sync2[i] != pins_clean[i] && tick && cnt[i] == CNT_W'(STABLE_TICKS - 1);
      cnt_nxt[i] = (sync2[i] == pins_clean[i] || accept[i]) ? '0 : tick ? cnt[i] + 1'b1 : cnt[i];
    end
  end
  // register read mux, unused upper bits read 0
  always_comb begin
    rdata = addr[3:0] == 4'h0 ? 32'(pins_clean) :
            addr[3:0] == 4'h4 ? 32'(rise_en) :
            addr[3:0] == 4'h8 ? 32'(fall_en) :
            addr[3:0] == 4'hC ? 32'(pending) : '0;
  end
  // synchroniser, prescaler, debounce state and register bank; a new edge beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      pins_clean <= '0;
      rise_en    <= '0;
      fall_en    <= '0;
      pending    <= '0;
      presc      <= '0;
      for (int i = 0; i < NPINS; i++) cnt[i] <= '0;
    end else begin
      sync1      <= pins_in;
      sync2      <= sync1;
      pins_clean <= clean_nxt;
      presc      <= tick ? '0 : presc + 1'b1;
      for (int i = 0; i < NPINS; i++) cnt[i] <= cnt_nxt[i];
      if (we && addr[3:0] == 4'h4) rise_en <= wdata[NPINS-1:0];
      if (we && addr[3:0] == 4'h8) fall_en <= wdata[NPINS-1:0];
      pending <= (pending & ~clr) | (rise & rise_en) | (fall & fall_en);
    end
  end
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner: scoreboard bench for the pin conditioner with default parameters
module tb_gpio_input_conditioner;
  logic        clk = 0, reset, we;
  logic [31:0] addr, wdata, rdata, pins_in, pins_clean;
  logic        irq;
  int          compared = 0, mismatched = 0;
  typedef struct {
    int          src;
    logic [31:0] act, lo, hi;
    string       name;
  } chk_t;
  chk_t q[$];

  gpio_input_conditioner dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
    .pins_in(pins_in), .pins_clean(pins_clean), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] v;
      c = q.pop_front();
      v = c.src == 0 ? rdata : c.src == 1 ? pins_clean : c.src == 2 ? {31'b0, irq} : c.act;
      compared++;
      if (v < c.lo || v > c.hi) begin
        mismatched++;
        $display("FAIL %s: got 0x%0h, want 0x%0h..0x%0h", c.name, v, c.lo, c.hi);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic exp_eq(input int src, input logic [31:0] v, input string nm);
    chk_t c;
    c.src = src; c.act = 0; c.lo = v; c.hi = v; c.name = nm;
    q.push_back(c);
  endtask

  task automatic rng(input int act, input int lo, input int hi, input string nm);
    chk_t c;
    c.src = 3; c.act = act; c.lo = lo; c.hi = hi; c.name = nm;
    q.push_back(c);
  endtask

  task automatic flush();
    @(negedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d;
    step();
    we = 0;
  endtask

  task automatic do_reset(input logic [31:0] p);
    pins_in = p; reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic wait_bit(input int b, input logic lvl, output int n);
    n = 0;
    while (pins_clean[b] != lvl && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] acc;
    reset = 1; pins_in = '1; we = 0; addr = 0; wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_eq(1, 0, "rst_clean"); exp_eq(2, 0, "rst_irq"); flush();
    addr = 32'h0; exp_eq(0, 0, "rst_rd0"); flush();
    addr = 32'h4; exp_eq(0, 0, "rst_rd4"); flush();
    addr = 32'h8; exp_eq(0, 0, "rst_rd8"); flush();
    addr = 32'hC; exp_eq(0, 0, "rst_rdC"); flush();
    step();
    reset = 0;
    n = 0;
    while (pins_clean != '1 && n < 100) begin
      step();
      n++;
    end
    compared++;
    if (pins_clean !== 32'hFFFF_FFFF) begin
      mismatched++;
      $display("FAIL inline_rst_release_clean: got 0x%0h", pins_clean);
    end
    rng(n, 51, 66, "rst_release_latency");
    exp_eq(1, 32'hFFFF_FFFF, "rst_release_clean");
    exp_eq(0, 0, "rst_release_pending");
    exp_eq(2, 0, "rst_release_irq");
    flush();

    do_reset(0);
    pins_in = 32'h8;
    wait_bit(3, 1, n);
    compared++;
    if (pins_clean !== 32'h8) begin
      mismatched++;
      $display("FAIL inline_rise3_clean: got 0x%0h", pins_clean);
    end
    rng(n, 51, 66, "rise3_latency"); exp_eq(1, 32'h8, "rise3_clean"); flush();
    pins_in = 0;
    wait_bit(3, 0, n);
    rng(n, 51, 66, "fall3_latency"); exp_eq(1, 0, "fall3_clean"); flush();

    bus_write(32'h4, 32'h20);
    acc = 0;
    pins_in = 32'h20;
    repeat (20) begin step(); acc |= pins_clean; end
    pins_in = 0;
    repeat (100) begin step(); acc |= pins_clean; end
    for (int k = 0; k < 500; k++) begin
      pins_in = ((k / 30) % 2 == 0) ? 32'h20 : 32'h0;
      step();
      acc |= pins_clean;
    end
    pins_in = 0;
    repeat (70) begin step(); acc |= pins_clean; end
    rng(acc, 0, 0, "glitch_clean_seen");
    addr = 32'hC; exp_eq(0, 0, "glitch_pending"); flush();

    bus_write(32'h4, 32'h1);
    bus_write(32'h8, 32'h0);
    addr = 32'hC;
    pins_in = 32'h1;
    wait_bit(0, 1, n);
    exp_eq(0, 32'h1, "int_pending"); exp_eq(2, 1, "int_irq");
    rng(n, 51, 66, "rise0_latency"); flush();
    pins_in = 0;
    wait_bit(0, 0, n);
    rng(n, 51, 66, "fall0_latency");
    exp_eq(0, 32'h1, "fall_disabled_pending"); exp_eq(2, 1, "fall_disabled_irq"); flush();
    bus_write(32'hC, 32'h1);
    compared++;
    if (irq !== 1'b0) begin
      mismatched++;
      $display("FAIL inline_w1c_irq: got %0b", irq);
    end
    exp_eq(0, 0, "w1c_pending"); exp_eq(2, 0, "w1c_irq"); flush();

    do_reset(32'h4);
    for (int k = 1; k <= 63; k++) begin
      step();
      if (k == 1) begin we = 1; addr = 32'h4; wdata = 32'h4; end
      if (k == 2) begin we = 0; addr = 32'hC; end
    end
    exp_eq(0, 0, "coll_pre_pending"); exp_eq(1, 0, "coll_pre_clean"); flush();
    we = 1; wdata = 32'h4;
    step();
    exp_eq(0, 32'h4, "coll_set_wins"); exp_eq(1, 32'h4, "coll_clean"); flush();
    step();
    we = 0;
    exp_eq(0, 0, "coll_w1c_late"); exp_eq(2, 0, "coll_irq"); flush();

    do_reset(0);
    bus_write(32'h0, 32'hDEAD_BEEF);
    bus_write(32'h10, 32'hDEAD_BEEF);
    bus_write(32'h2, 32'hDEAD_BEEF);
    addr = 32'h0; exp_eq(0, 0, "clean_ro"); exp_eq(1, 0, "clean_pins_ro"); flush();
    addr = 32'h10; exp_eq(0, 0, "rd_0x10"); flush();
    addr = 32'h2; exp_eq(0, 0, "rd_0x2"); flush();
    addr = 32'h4; exp_eq(0, 0, "rise_en_untouched"); flush();
    bus_write(32'h8, 32'hA5A5_A5A5);
    addr = 32'h8; exp_eq(0, 32'hA5A5_A5A5, "fall_en_rw"); flush();
    addr = 32'hC; exp_eq(0, 0, "pending_after_decode"); exp_eq(2, 0, "irq_after_decode"); flush();

    flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
